addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Controller that shares one 18-bit pre-adder/subtractor unit in the DSP48A1 slice datapath among NREQ independent requesters. It arbitrates between requests (round-robin by default), registers the winner's operands and opcode onto the adder inputs, and captures the adder result. It then returns the result to the winner over a valid/ready response channel tagged with the requester index. It sits between the control logic of the requesting units and the combinational add/sub stage.

## Interface
- WIDTH, 18, operand/result width
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-index width, equal to clog2(NREQ)

- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  NREQ*WIDTH  operand A, slice i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_cin  in  NREQ  carry-in
- req_sub  in  NREQ  0 = add, 1 = subtract
- au_in1  out  WIDTH  adder IN1 (registered A)
- au_in2  out  WIDTH  adder IN2 (registered B)
- au_cin  out  1  adder carry-in (registered)
- au_opmode7  out  1  adder mode (registered req_sub)
- au_out  in  WIDTH  adder result
- au_cout  in  1  adder carry/borrow
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_data  out  WIDTH  registered au_out
- rsp_cout  out  1  registered au_cout

## Operation
- States:
  - IDLE: no transaction.
  - BUSY: operands on the adder, result settling.
  - DONE: response held.
- Acceptance window: requests are accepted only in IDLE, or in DONE in a cycle where rsp_ready=1.
- Grant: combinational, among asserted req_valid bits.
  - Round-robin search starts at pointer rr_ptr.
  - Winner g gets req_ready[g]=1 only while the acceptance window is open.
- On accept (req_valid[g] & req_ready[g]):
  - Register au_in1=A[g], au_in2=B[g], au_cin=cin[g], au_opmode7=sub[g], and id=g.
  - rr_ptr <= (g+1) mod NREQ.
  - Next state is BUSY.
- BUSY, always exactly one cycle: capture rsp_data=au_out, rsp_cout=au_cout, rsp_id=id; rsp_valid <= 1; next state DONE.
- DONE:
  - rsp_ready=0: hold all response fields stable.
  - rsp_ready=1 with a new accept: go to BUSY; rsp_valid drops next cycle.
  - rsp_ready=1 with no accept: go to IDLE; rsp_valid <= 0.
- Adder contract (the controller only passes operands through; bench checks against this):
  - opmode7=0: {cout,out} = IN1+IN2+cin.
  - opmode7=1: {cout,out} = IN2-(IN1+cin), taken modulo 2^(WIDTH+1).
- Requester rules:
  - A requester holds req_valid and its operands stable until req_ready.
  - Deasserting req_valid before grant is permitted and loses nothing.
- au_* registers keep the last issued values outside BUSY.

## Timing
- Reset: state IDLE, rr_ptr=0. All of req_ready, au_in1, au_in2, au_cin, au_opmode7, rsp_valid, rsp_id, rsp_data and rsp_cout are 0.
- Latency: accept edge at cycle 0, au_* valid in cycle 1, rsp_valid=1 in cycle 2.
- Throughput: one transaction per 2 cycles while rsp_ready is held at 1.
- Multiple simultaneous req_valid: exactly one is granted. Others stay pending with req_ready=0.
- Round-robin wrap: pointer at NREQ-1 wraps to 0, and the search wraps modulo NREQ.
- Single requester asserted continuously: it is granted every window regardless of rr_ptr.
- Backpressure: with rsp_ready=0 in DONE, all req_ready are 0 and nothing is lost or overwritten.
- RST mid-transaction: the in-flight operation is discarded and state returns to IDLE. Next cycle rsp_valid=0, and no response is emitted for the dropped request.
- RST has priority over an accept in the same cycle.

## Configuration
- ADDSUB_ARB_FIXED_PRIO_EN defined:
  - Fixed priority; lowest asserted index wins.
  - rr_ptr logic is removed.
- Undefined (default): round-robin as described.
- All other behaviour and timing are identical in both builds.

## Test plan
- Add: req 0 with A=5, B=3, cin=1, sub=0 -> rsp_valid in cycle 2 with rsp_data=9, rsp_cout=0, rsp_id=0.
- Subtract borrow: req 2 with A=10, B=3, cin=0, sub=1 -> rsp_data=0x3FFF9, rsp_cout=1, rsp_id=2. The case A=3, B=10 gives rsp_data=7, rsp_cout=0.
- Add overflow: A=0x3FFFF, B=1, cin=0, sub=0 -> rsp_data=0, rsp_cout=1.
- Round-robin: all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles. With ADDSUB_ARB_FIXED_PRIO_EN defined -> 0 granted every time.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> response fields constant and req_ready=0. Raising rsp_ready accepts the next pending request that same cycle.
- Reset mid-op: RST in the BUSY cycle -> no rsp_valid afterwards, all outputs 0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one pre-adder/subtractor among NREQ requesters.
// Grants one request per acceptance window, drives the winner's operands onto
// the adder inputs, captures the result one cycle later and returns it over a
// valid/ready response channel tagged with the requester index.
//
// Build option: define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins, no round-robin pointer). Default is round-robin.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no transaction in flight
// BUSY  | operands on the adder, result settling
// DONE  | response held until rsp_ready

module addsub_arbiter #(
   parameter int WIDTH = 18,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   input  logic [NREQ-1:0]       req_sub,
   output logic [WIDTH-1:0]      au_in1,
   output logic [WIDTH-1:0]      au_in2,
   output logic                  au_cin,
   output logic                  au_opmode7,
   input  logic [WIDTH-1:0]      au_out,
   input  logic                  au_cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_cout
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               win_open;
   logic               any_valid;
   logic               accept;
   logic [IDW-1:0]     gnt_idx;
   logic [IDW-1:0]     id_q;
   logic [WIDTH-1:0]   au_in1_q, au_in2_q, rsp_data_q;
   logic               au_cin_q, au_opmode7_q, rsp_valid_q, rsp_cout_q;
   logic [IDW-1:0]     rsp_id_q;

   assign any_valid = |req_valid;
   // Reset closes the window so an accept can never coincide with RST.
   assign win_open  = !RST && ((state_q == S_IDLE) || ((state_q == S_DONE) && rsp_ready));
   assign accept    = win_open && any_valid;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
   // Fixed priority: scan from the top so the lowest asserted index wins.
   always_comb begin
      gnt_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[k]) gnt_idx = IDW'(k);
      end
   end
`else
   logic [IDW-1:0] rr_ptr_q;
   logic [IDW-1:0] rr_idx;
   logic           found;

   // Round-robin: first asserted request at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_idx = '0;
      found   = 1'b0;
      rr_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         rr_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
         if (!found && req_valid[rr_idx]) begin
            gnt_idx = rr_idx;
            found   = 1'b1;
         end
      end
   end

   // Pointer moves just past the winner on every accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr_q <= '0;
      end else if (accept) begin
         rr_ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end
`endif

   // One-hot ready to the winner while the acceptance window is open.
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; BUSY always lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_BUSY;
         S_BUSY: state_d = S_DONE;
         S_DONE: if (rsp_ready) state_d = accept ? S_BUSY : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand issue on accept, result capture in BUSY, response retire in DONE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         au_in1_q     <= '0;
         au_in2_q     <= '0;
         au_cin_q     <= 1'b0;
         au_opmode7_q <= 1'b0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_cout_q   <= 1'b0;
      end else begin
         if (accept) begin
            au_in1_q     <= req_a[gnt_idx*WIDTH +: WIDTH];
            au_in2_q     <= req_b[gnt_idx*WIDTH +: WIDTH];
            au_cin_q     <= req_cin[gnt_idx];
            au_opmode7_q <= req_sub[gnt_idx];
            id_q         <= gnt_idx;
         end
         if (state_q == S_BUSY) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= au_out;
            rsp_cout_q  <= au_cout;
         end else if ((state_q == S_DONE) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign au_in1     = au_in1_q;
   assign au_in2     = au_in2_q;
   assign au_cin     = au_cin_q;
   assign au_opmode7 = au_opmode7_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_cout   = rsp_cout_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed operations push hand-computed
// responses into a queue, a negedge monitor pops and compares on handshake.
module tb_addsub_arbiter;
   localparam int W = 18;
   localparam int N = 4;

   logic           CLK, RST;
   logic [N-1:0]   req_valid, req_ready, req_cin, req_sub;
   logic [N*W-1:0] req_a, req_b;
   logic [W-1:0]   au_in1, au_in2, au_out, rsp_data;
   logic           au_cin, au_opmode7, au_cout, rsp_valid, rsp_ready, rsp_cout;
   logic [1:0]     rsp_id;
   logic [W:0]     add_r;

   addsub_arbiter #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
      .au_in1(au_in1), .au_in2(au_in2), .au_cin(au_cin), .au_opmode7(au_opmode7),
      .au_out(au_out), .au_cout(au_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout));

   // Adder contract model
   always_comb begin
      if (au_opmode7) add_r = {1'b0, au_in2} - ({1'b0, au_in1} + (W+1)'(au_cin));
      else            add_r = {1'b0, au_in1} + {1'b0, au_in2} + (W+1)'(au_cin);
   end
   assign au_out  = add_r[W-1:0];
   assign au_cout = add_r[W];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {int r; logic [W-1:0] a; logic [W-1:0] b; logic cin; logic sub;} op_t;
   typedef struct {logic [1:0] id; logic [W-1:0] data; logic cout;} exp_t;

   op_t  pend[$];
   exp_t expq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic [N-1:0] acc, s_ready;
   logic         s_valid, s_cout, s_cin, s_op;
   logic [1:0]   s_id;
   logic [W-1:0] s_data, s_in1, s_in2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
      op_t o;
      o.r = r; o.a = a; o.b = b; o.cin = cin; o.sub = sub;
      pend.push_back(o);
   endtask

   task automatic push_exp(input logic [1:0] id, input logic [W-1:0] d, input logic c);
      exp_t e;
      e.id = id; e.data = d; e.cout = c;
      expq.push_back(e);
   endtask

   // Present the oldest pending op of each requester
   task automatic drive();
      req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_sub = '0;
      for (int i = 0; i < N; i++) begin
         bit found;
         found = 1'b0;
         for (int j = 0; j < pend.size(); j++) begin
            if (!found && pend[j].r == i) begin
               found = 1'b1;
               req_valid[i] = 1'b1;
               req_a[i*W +: W] = pend[j].a;
               req_b[i*W +: W] = pend[j].b;
               req_cin[i] = pend[j].cin;
               req_sub[i] = pend[j].sub;
            end
         end
      end
   endtask

   // One cycle: snapshot at negedge, then update requesters after the edge
   task automatic step();
      @(negedge CLK);
      s_ready = req_ready; s_valid = rsp_valid; s_id = rsp_id; s_data = rsp_data;
      s_cout = rsp_cout; s_in1 = au_in1; s_in2 = au_in2; s_cin = au_cin; s_op = au_opmode7;
      acc = req_valid & req_ready;
      if ($countones(req_ready) > 1) chk("ready_onehot", 64'(req_ready), 64'(acc));
      @(posedge CLK);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            int k;
            k = -1;
            for (int j = 0; j < pend.size(); j++) if (k < 0 && pend[j].r == i) k = j;
            if (k >= 0) pend.delete(k);
         end
      end
      if (acc != '0) acc_cyc = cyc;
      drive();
   endtask

   task automatic wait_accept(output logic [N-1:0] g);
      bit got;
      got = 1'b0;
      g = '0;
      for (int n = 0; n < 30 && !got; n++) begin
         step();
         if (acc != '0) begin got = 1'b1; g = acc; end
      end
      if (!got) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      for (int n = 0; n < 60 && expq.size() != 0; n++) step();
      chk("drain_empty", 64'(expq.size()), 64'd0);
   endtask

   // Scoreboard monitor
   always @(negedge CLK) begin
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (expq.size() == 0) begin
            chk("rsp_unexpected", {46'd0, rsp_id, rsp_data}, 64'hDEAD_BEEF_DEAD_BEEF);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
         end
      end
   end

   logic [N-1:0] g;
   logic [N-1:0] rr_exp [5];
   int           rr_cyc [5];

   initial begin
      RST = 1'b1;
      rsp_ready = 1'b1;
      drive();
      step();
      step();
      chk("reset_outs", {s_in1, s_in2, s_cin, s_op, s_valid, s_id, s_data, s_cout, s_ready}, 64'd0);
      RST = 1'b0;

      // Add with carry-in, latency check
      push_op(0, 18'd5, 18'd3, 1'b1, 1'b0);
      push_exp(2'd0, 18'd9, 1'b0);
      drive();
      wait_accept(g);
      chk("add_grant", 64'(g), 64'b0001);
      step();
      chk("lat_c1_valid", 64'(s_valid), 64'd0);
      chk("au_regs", {26'd0, s_in1, s_in2, s_cin, s_op}, {26'd0, 18'd5, 18'd3, 1'b1, 1'b0});
      step();
      chk("lat_c2_valid", 64'(s_valid), 64'd1);
      drain();

      // Add overflow on requester 1
      push_op(1, 18'h3FFFF, 18'd1, 1'b0, 1'b0);
      push_exp(2'd1, 18'd0, 1'b1);
      drive();
      wait_accept(g);
      chk("ovf_grant", 64'(g), 64'b0010);
      drain();

      // Subtract with borrow and without, back-to-back on requester 2
      push_op(2, 18'd10, 18'd3, 1'b0, 1'b1);
      push_op(2, 18'd3, 18'd10, 1'b0, 1'b1);
      push_exp(2'd2, 18'h3FFF9, 1'b1);
      push_exp(2'd2, 18'd7, 1'b0);
      drive();
      wait_accept(g);
      chk("sub1_grant", 64'(g), 64'b0100);
      rr_cyc[0] = acc_cyc;
      wait_accept(g);
      chk("sub2_grant", 64'(g), 64'b0100);
      chk("single_req_spacing", 64'(acc_cyc - rr_cyc[0]), 64'd2);
      drain();

      // Requester 3 alone moves the pointer to wrap back to 0
      push_op(3, 18'd100, 18'd200, 1'b0, 1'b0);
      push_exp(2'd3, 18'd300, 1'b0);
      drive();
      wait_accept(g);
      chk("r3_grant", 64'(g), 64'b1000);
      drain();

      // All four requesters contend
      push_op(0, 18'd1, 18'd2, 1'b0, 1'b0);
      push_op(0, 18'd7, 18'd7, 1'b1, 1'b0);
      push_op(1, 18'h20000, 18'h20000, 1'b0, 1'b0);
      push_op(2, 18'd1, 18'd0, 1'b0, 1'b1);
      push_op(3, 18'h100, 18'h300, 1'b1, 1'b1);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0010;
      rr_exp[3] = 4'b0100; rr_exp[4] = 4'b1000;
      push_exp(2'd0, 18'd3, 1'b0);
      push_exp(2'd0, 18'd15, 1'b0);
      push_exp(2'd1, 18'd0, 1'b1);
      push_exp(2'd2, 18'h3FFFF, 1'b1);
      push_exp(2'd3, 18'h1FF, 1'b0);
`else
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
      push_exp(2'd0, 18'd3, 1'b0);
      push_exp(2'd1, 18'd0, 1'b1);
      push_exp(2'd2, 18'h3FFFF, 1'b1);
      push_exp(2'd3, 18'h1FF, 1'b0);
      push_exp(2'd0, 18'd15, 1'b0);
`endif
      drive();
      for (int i = 0; i < 5; i++) begin
         wait_accept(g);
         chk("contend_grant", 64'(g), 64'(rr_exp[i]));
         rr_cyc[i] = acc_cyc;
      end
      for (int i = 1; i < 5; i++) chk("contend_spacing", 64'(rr_cyc[i] - rr_cyc[i-1]), 64'd2);
      drain();

      // Backpressure in DONE
      rsp_ready = 1'b0;
      push_op(1, 18'h155, 18'h0AA, 1'b1, 1'b0);
      push_exp(2'd1, 18'h200, 1'b0);
      drive();
      wait_accept(g);
      chk("bp_grant", 64'(g), 64'b0010);
      step();
      step();
      chk("bp_valid", 64'(s_valid), 64'd1);
      push_op(3, 18'h10, 18'h30, 1'b0, 1'b1);
      push_exp(2'd3, 18'h20, 1'b0);
      drive();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold", {44'd0, s_valid, s_id, s_data, s_cout}, {44'd0, 1'b1, 2'd1, 18'h200, 1'b0});
         chk("bp_ready_low", 64'(s_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_release_grant", 64'(s_ready), 64'b1000);
      drain();

      // Reset during BUSY drops the operation and clears the pointer
      push_op(1, 18'd5, 18'd5, 1'b0, 1'b0);
      drive();
      wait_accept(g);
      chk("rst_pre_grant", 64'(g), 64'b0010);
      RST = 1'b1;
      step();
      RST = 1'b0;
      step();
      chk("rst_outs", {s_in1, s_in2, s_cin, s_op, s_valid, s_id, s_data, s_cout, s_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_no_rsp", 64'(s_valid), 64'd0);
      end
      push_op(0, 18'd9, 18'd4, 1'b0, 1'b1);
      push_op(2, 18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0);
      push_exp(2'd0, 18'h3FFFB, 1'b1);
      push_exp(2'd2, 18'h3FFFF, 1'b1);
      drive();
      wait_accept(g);
      chk("rst_next_grant", 64'(g), 64'b0001);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
